csr_perf_counters: RTL and testbench

- Parametrised hardware performance monitor bank; successor to the fixed mcycle/minstret pair in the current CSR unit.
- Implements mcycle, minstret, NUM_HPM programmable mhpmcounters with event selectors, mcountinhibit, mcounteren/scounteren privilege gating, user read-only shadows and overflow interrupt flags.
- Sits beside the CSR execution unit. The CSR unit forwards the request whenever OUT_hit is set; this block returns its registered result one cycle later.

---
 rtl/csr_perf_counters_pkg.sv | 40 ++++
 rtl/csr_perf_counters_perf_counter.sv | 45 ++++
 rtl/csr_perf_counters.sv | 206 ++++++++++++++++++++
 tb/tb_csr_perf_counters.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_perf_counters_pkg.sv
// Shared definitions for the performance-counter CSR bank: address bases,
// CSR operation encoding, privilege levels and the read-modify-write helper.
package csr_perf_counters_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MHPMEVENT31   = 12'h33F;
    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_SCOUNTEREN    = 12'h106;

    // Counter index within a bank: 0=cycle, 1=time, 2=instret, 3+i=hpm[i].
    localparam int IDX_TIME = 1;
    localparam int IDX_HPM0 = 3;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int OF_BIT = 31;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_t;

    function automatic logic [31:0] csr_apply(input csr_op_t op, input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (op)
            OP_WRITE: csr_apply = wdata;
            OP_SET:   csr_apply = old_val | wdata;
            OP_CLEAR: csr_apply = old_val & ~wdata;
            default:  csr_apply = old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_perf_counters_perf_counter.sv
// One CNT_W-bit event counter with a 32-bit lo/hi write port. A write to
// either half wins over that cycle's increment; carry reports the wrap.
module perf_counter #(
    parameter int CNT_W = 64,
    parameter int INC_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] cnt,
    output logic             carry
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc);
        cnt_d = cnt_q;
        carry = 1'b0;
        if (wr_lo) begin
            cnt_d[31:0] = wdata;
        end else if (wr_hi) begin
            cnt_d[CNT_W-1:32] = wdata[CNT_W-33:0];
        end else if (en) begin
            cnt_d = sum[CNT_W-1:0];
            carry = sum[CNT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/csr_perf_counters.sv
// Performance monitor CSR bank: mcycle, minstret, NUM_HPM programmable
// counters, inhibit/enable registers, user shadows and overflow interrupt.
module csr_perf_counters
    import csr_perf_counters_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int CNT_W      = 64,
    parameter int NUM_EVENTS = 8,
    parameter int EVT_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        IN_valid,
    input  logic [11:0]                 IN_addr,
    input  logic [1:0]                  IN_op,
    input  logic [31:0]                 IN_wdata,
    input  logic [1:0]                  IN_priv,
    input  logic [EVT_W-1:0]            IN_retireCnt,
    input  logic [NUM_EVENTS*EVT_W-1:0] IN_events,
    output logic                        OUT_hit,
    output logic                        OUT_valid,
    output logic [31:0]                 OUT_rdata,
    output logic                        OUT_illegal,
    output logic                        OUT_ovfIrq
);

    // Handshake: IN_valid is a single-cycle request with no backpressure; every
    // hit request yields exactly one OUT_valid pulse on the following edge.
    localparam int NUM_CNT = NUM_HPM + 2;
    localparam int NH      = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] CEN_MASK = 32'((64'd1 << (NUM_HPM + 3)) - 64'd1);
    localparam logic [31:0] INH_MASK = CEN_MASK & ~32'h2;

    logic [31:0] inhibit_q, inhibit_d;
    logic [31:0] mcounteren_q, mcounteren_d;
    logic [31:0] scounteren_q, scounteren_d;
    logic [7:0]  sel_q [NH];
    logic [7:0]  sel_d [NH];
    logic [NH-1:0] of_q, of_d;
    logic        valid_q, valid_d;
    logic        illegal_q, illegal_d;
    logic [31:0] rdata_q, rdata_d;

    logic [CNT_W-1:0]   cnt_val [NUM_CNT];
    logic [EVT_W-1:0]   cnt_inc [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_en, cnt_carry, wr_lo, wr_hi;

    logic [4:0]  idx, cnt_k, hpm_k;
    logic        is_hi, cnt_space, is_m_cnt, is_shadow, is_inhibit, is_event, is_mcen, is_scen;
    logic        hit, hpm_impl, cnt_impl, illegal, req, do_write, ovf_irq;
    logic [31:0] old_val, new_val;
    logic        unused_bits;

    assign idx        = IN_addr[4:0];
    assign is_hi      = IN_addr[7];
    assign cnt_space  = (IN_addr[6:5] == 2'b00);
    assign is_m_cnt   = (IN_addr[11:8] == CSR_MCYCLE[11:8]) && cnt_space && (idx != 5'(IDX_TIME));
    assign is_shadow  = (IN_addr[11:8] == CSR_CYCLE[11:8]) && cnt_space;
    assign is_inhibit = (IN_addr == CSR_MCOUNTINHIBIT);
    assign is_event   = (IN_addr >= CSR_MHPMEVENT3) && (IN_addr <= CSR_MHPMEVENT31);
    assign is_mcen    = (IN_addr == CSR_MCOUNTEREN);
    assign is_scen    = (IN_addr == CSR_SCOUNTEREN);
    assign hit        = is_m_cnt | is_shadow | is_inhibit | is_event | is_mcen | is_scen;

    assign hpm_k    = idx - 5'(IDX_HPM0);
    assign hpm_impl = (idx >= 5'(IDX_HPM0)) && (int'(hpm_k) < NUM_HPM);
    assign cnt_impl = (idx == 5'd0) || (idx == 5'd2) || hpm_impl;
    // Bank index 0 -> mcycle, 2 -> minstret, 3+i -> hpm[i] at slot 2+i.
    assign cnt_k    = (idx == 5'd0) ? 5'd0 : idx - 5'd1;

    assign unused_bits = ^{cnt_carry[1:0], IN_events[EVT_W-1:0]};

    always_comb begin
        cnt_en     = '0;
        cnt_inc    = '{default: '0};
        cnt_en[0]  = ~inhibit_q[0];
        cnt_inc[0] = EVT_W'(1);
        cnt_en[1]  = ~inhibit_q[2];
        cnt_inc[1] = IN_retireCnt;
        for (int i = 0; i < NUM_HPM; i++) begin
            cnt_en[2+i] = ~inhibit_q[3+i];
            for (int e = 1; e < NUM_EVENTS; e++) begin
                if (sel_q[i] == 8'(e)) cnt_inc[2+i] = IN_events[e*EVT_W +: EVT_W];
            end
        end
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W), .INC_W(EVT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst),
            .en    (cnt_en[k]),
            .inc   (cnt_inc[k]),
            .wr_lo (wr_lo[k]),
            .wr_hi (wr_hi[k]),
            .wdata (new_val),
            .cnt   (cnt_val[k]),
            .carry (cnt_carry[k])
        );
    end

    always_comb begin
        old_val = '0;
        if ((is_m_cnt || is_shadow) && cnt_impl) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (cnt_k == 5'(k)) old_val = is_hi ? 32'(cnt_val[k] >> 32) : cnt_val[k][31:0];
            end
        end
        if (is_event && hpm_impl) begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (hpm_k == 5'(i)) old_val = {of_q[i], 23'b0, sel_q[i]};
            end
        end
        if (is_inhibit) old_val = inhibit_q;
        if (is_mcen)    old_val = mcounteren_q;
        if (is_scen)    old_val = scounteren_q;
    end

    always_comb begin
        illegal = 1'b0;
        if (is_m_cnt || is_inhibit || is_event || is_mcen) begin
            illegal = (IN_priv != PRIV_M);
        end else if (is_scen) begin
            illegal = (IN_priv < PRIV_S);
        end else if (is_shadow) begin
            illegal = (idx == 5'(IDX_TIME)) || (IN_op != OP_READ)
                   || (IN_priv != PRIV_M && !mcounteren_q[idx])
                   || (IN_priv == PRIV_U && !scounteren_q[idx]);
        end
    end

    always_comb begin
        req          = IN_valid && hit;
        do_write     = req && !illegal && (IN_op != OP_READ);
        new_val      = csr_apply(csr_op_t'(IN_op), old_val, IN_wdata);
        wr_lo        = '0;
        wr_hi        = '0;
        inhibit_d    = inhibit_q;
        mcounteren_d = mcounteren_q;
        scounteren_d = scounteren_q;
        sel_d        = sel_q;
        of_d         = of_q;
        if (do_write && is_m_cnt && cnt_impl) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (cnt_k == 5'(k)) begin
                    wr_hi[k] = is_hi;
                    wr_lo[k] = ~is_hi;
                end
            end
        end
        if (do_write && is_inhibit) inhibit_d    = new_val & INH_MASK;
        if (do_write && is_mcen)    mcounteren_d = new_val & CEN_MASK;
        if (do_write && is_scen)    scounteren_d = new_val & CEN_MASK;
        if (do_write && is_event && hpm_impl) begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (hpm_k == 5'(i)) begin
                    sel_d[i] = new_val[7:0];
                    of_d[i]  = new_val[OF_BIT];
                end
            end
        end
        // A hardware wrap overrides a software clear landing on the same edge.
        for (int i = 0; i < NUM_HPM; i++) begin
            if (cnt_carry[2+i]) of_d[i] = 1'b1;
        end
        valid_d   = req;
        illegal_d = req && illegal;
        rdata_d   = (req && !illegal) ? old_val : '0;
    end

    always_comb begin
        ovf_irq = 1'b0;
        for (int i = 0; i < NUM_HPM; i++) begin
            ovf_irq = ovf_irq | (of_q[i] & ~inhibit_q[3+i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inhibit_q    <= '0;
            mcounteren_q <= '0;
            scounteren_q <= '0;
            of_q         <= '0;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
            rdata_q      <= '0;
            for (int i = 0; i < NH; i++) sel_q[i] <= '0;
        end else begin
            inhibit_q    <= inhibit_d;
            mcounteren_q <= mcounteren_d;
            scounteren_q <= scounteren_d;
            of_q         <= of_d;
            valid_q      <= valid_d;
            illegal_q    <= illegal_d;
            rdata_q      <= rdata_d;
            for (int i = 0; i < NH; i++) sel_q[i] <= sel_d[i];
        end
    end

    assign OUT_hit     = hit;
    assign OUT_valid   = valid_q;
    assign OUT_rdata   = rdata_q;
    assign OUT_illegal = illegal_q;
    assign OUT_ovfIrq  = ovf_irq;

endmodule

// File: tb/tb_csr_perf_counters.sv
// Directed bench for csr_perf_counters: counting, event selection, overflow,
// privilege gating, write/increment collisions and asynchronous reset.
module tb_csr_perf_counters;

    localparam int NUM_HPM    = 4;
    localparam int CNT_W      = 64;
    localparam int NUM_EVENTS = 8;
    localparam int EVT_W      = 3;

    localparam logic [1:0] PM = 2'd3, PS = 2'd1, PU = 2'd0;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, ST = 2'd2, CL = 2'd3;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        IN_valid = 1'b0;
    logic [11:0]                 IN_addr = '0;
    logic [1:0]                  IN_op = '0;
    logic [31:0]                 IN_wdata = '0;
    logic [1:0]                  IN_priv = '0;
    logic [EVT_W-1:0]            IN_retireCnt = '0;
    logic [NUM_EVENTS*EVT_W-1:0] IN_events = '0;
    logic                        OUT_hit, OUT_valid, OUT_illegal, OUT_ovfIrq;
    logic [31:0]                 OUT_rdata;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    logic        rsp_valid, rsp_illegal;
    logic [31:0] rsp_rdata;
    logic [31:0] exp_cyc;

    csr_perf_counters #(
        .NUM_HPM(NUM_HPM), .CNT_W(CNT_W), .NUM_EVENTS(NUM_EVENTS), .EVT_W(EVT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_valid     (IN_valid),
        .IN_addr      (IN_addr),
        .IN_op        (IN_op),
        .IN_wdata     (IN_wdata),
        .IN_priv      (IN_priv),
        .IN_retireCnt (IN_retireCnt),
        .IN_events    (IN_events),
        .OUT_hit      (OUT_hit),
        .OUT_valid    (OUT_valid),
        .OUT_rdata    (OUT_rdata),
        .OUT_illegal  (OUT_illegal),
        .OUT_ovfIrq   (OUT_ovfIrq)
    );

    always #5 clk = ~clk;

    // Reference cycle count: edges seen since reset release.
    always @(posedge clk) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and capture the registered response one edge later.
    task automatic csr(input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [1:0] priv);
        IN_valid = 1'b1;
        IN_op    = op;
        IN_addr  = addr;
        IN_wdata = wdata;
        IN_priv  = priv;
        @(posedge clk);
        #1;
        IN_valid    = 1'b0;
        IN_op       = RD;
        IN_wdata    = '0;
        rsp_valid   = OUT_valid;
        rsp_rdata   = OUT_rdata;
        rsp_illegal = OUT_illegal;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_valid", OUT_valid, 0);
        check("rst_rdata", OUT_rdata, 0);
        check("rst_illegal", OUT_illegal, 0);
        check("rst_ovf", OUT_ovfIrq, 0);
        rst = 1'b1;

        // mcycle after 10 idle cycles, single-cycle valid pulse
        tick(10);
        csr(RD, 12'hB00, 0, PM);
        check("mcycle_valid", rsp_valid, 1);
        check("mcycle_10", rsp_rdata, 32'd10);
        check("mcycle_legal", rsp_illegal, 0);
        tick(1);
        check("valid_pulse", OUT_valid, 0);

        // Event selection
        csr(WR, 12'h323, 32'd2, PM);
        IN_events = '0;
        IN_events[2*EVT_W +: EVT_W] = 3'd3;
        tick(4);
        IN_events = '0;
        csr(RD, 12'hB03, 0, PM);
        check("hpm3_12", rsp_rdata, 32'd12);
        csr(WR, 12'h323, 32'd9, PM);
        csr(RD, 12'h323, 0, PM);
        check("sel_9", rsp_rdata, 32'd9);
        IN_events = 24'o33333333;
        tick(4);
        IN_events = '0;
        csr(RD, 12'hB03, 0, PM);
        check("sel_oob_12", rsp_rdata, 32'd12);

        // Overflow, OF flag, interrupt gating
        csr(WR, 12'h323, 32'd2, PM);
        csr(WR, 12'hB03, 32'hFFFF_FFFF, PM);
        csr(WR, 12'hB83, 32'hFFFF_FFFF, PM);
        IN_events[2*EVT_W +: EVT_W] = 3'd2;
        tick(1);
        IN_events = '0;
        check("ovf_irq_set", OUT_ovfIrq, 1);
        csr(RD, 12'hB03, 0, PM);
        check("wrap_lo", rsp_rdata, 32'd1);
        csr(RD, 12'hB83, 0, PM);
        check("wrap_hi", rsp_rdata, 32'd0);
        csr(RD, 12'h323, 0, PM);
        check("of_bit", rsp_rdata, 32'h8000_0002);
        csr(ST, 12'h320, 32'd8, PM);
        check("ovf_inhibited", OUT_ovfIrq, 0);
        csr(CL, 12'h320, 32'd8, PM);
        check("ovf_uninhibited", OUT_ovfIrq, 1);
        csr(CL, 12'h323, 32'h8000_0000, PM);
        csr(RD, 12'h323, 0, PM);
        check("of_cleared", rsp_rdata, 32'd2);
        check("ovf_cleared", OUT_ovfIrq, 0);
        csr(WR, 12'hB03, 32'hFFFF_FFFF, PM);
        csr(WR, 12'hB83, 32'hFFFF_FFFF, PM);
        IN_events[2*EVT_W +: EVT_W] = 3'd1;
        csr(CL, 12'h323, 32'h8000_0000, PM);
        IN_events = '0;
        csr(RD, 12'h323, 0, PM);
        check("of_hw_wins", rsp_rdata, 32'h8000_0002);
        check("ovf_hw_wins", OUT_ovfIrq, 1);
        csr(RD, 12'hB03, 0, PM);
        check("wrap_zero", rsp_rdata, 32'd0);

        // Privilege gating and shadows
        csr(WR, 12'h306, 32'hFFFF_FFFF, PM);
        csr(RD, 12'h306, 0, PM);
        check("mcen_mask", rsp_rdata, 32'h7F);
        csr(WR, 12'h306, 32'd1, PM);
        csr(RD, 12'hC00, 0, PU);
        check("u_c00_illegal", rsp_illegal, 1);
        check("u_c00_rdata0", rsp_rdata, 0);
        csr(WR, 12'h106, 32'd1, PU);
        check("u_scen_illegal", rsp_illegal, 1);
        csr(WR, 12'h106, 32'd1, PS);
        check("s_scen_legal", rsp_illegal, 0);
        exp_cyc = 32'(edges);
        csr(RD, 12'hC00, 0, PU);
        check("u_c00_legal", rsp_illegal, 0);
        check("u_c00_cycles", rsp_rdata, exp_cyc);
        csr(WR, 12'hC00, 32'd5, PU);
        check("u_c00_write", rsp_illegal, 1);
        csr(RD, 12'hC02, 0, PU);
        check("u_c02_gated", rsp_illegal, 1);
        csr(RD, 12'hC01, 0, PM);
        check("time_illegal", rsp_illegal, 1);
        csr(RD, 12'hB00, 0, PS);
        check("s_mbank_illegal", rsp_illegal, 1);
        IN_addr = 12'hB07;
        #1;
        check("warl_hit", OUT_hit, 1);
        csr(WR, 12'hB07, 32'hDEAD_BEEF, PM);
        csr(RD, 12'hB07, 0, PM);
        check("warl_read0", rsp_rdata, 0);
        check("warl_legal", rsp_illegal, 0);

        // minstret write/increment collision and inhibit
        IN_retireCnt = 3'd3;
        csr(WR, 12'hB02, 32'd100, PM);
        csr(RD, 12'hB02, 0, PM);
        check("instret_write_wins", rsp_rdata, 32'd100);
        IN_retireCnt = 3'd0;
        csr(RD, 12'hB02, 0, PM);
        check("instret_103", rsp_rdata, 32'd103);
        csr(WR, 12'h320, 32'hFFFF_FFFF, PM);
        csr(RD, 12'h320, 0, PM);
        check("inhibit_mask", rsp_rdata, 32'h7D);
        csr(CL, 12'h320, 32'hFFFF_FFFB, PM);
        IN_retireCnt = 3'd3;
        tick(1);
        IN_retireCnt = 3'd0;
        csr(RD, 12'hB02, 0, PM);
        check("instret_inhibited", rsp_rdata, 32'd103);
        csr(CL, 12'h320, 32'd4, PM);
        check("inhibit_clr_old", rsp_rdata, 32'd4);
        IN_retireCnt = 3'd3;
        tick(1);
        IN_retireCnt = 3'd0;
        csr(RD, 12'hB02, 0, PM);
        check("instret_106", rsp_rdata, 32'd106);

        // Asynchronous reset during a back-to-back read stream
        IN_valid = 1'b1;
        IN_op    = RD;
        IN_addr  = 12'hB00;
        IN_priv  = PM;
        tick(2);
        check("stream_valid", OUT_valid, 1);
        check("stream_ovf", OUT_ovfIrq, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", OUT_valid, 0);
        check("async_rdata", OUT_rdata, 0);
        check("async_ovf", OUT_ovfIrq, 0);
        tick(1);
        check("rst_drop", OUT_valid, 0);
        IN_valid = 1'b0;
        rst = 1'b1;
        tick(5);
        csr(RD, 12'hB00, 0, PM);
        check("post_rst_valid", rsp_valid, 1);
        check("post_rst_mcycle", rsp_rdata, 32'd5);
        csr(RD, 12'h323, 0, PM);
        check("post_rst_event", rsp_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
